// File: rtl/morse_tx_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : morse_tx_arbiter_pkg                                          |
// | Description : Shared definitions for the morse_tx source arbiter: FSM      |
// |               state encoding and the ASCII codes the arbiter emits.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package morse_tx_arbiter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;  // waiting for a requester
  localparam state_t ST_STREAM = 2'd1;  // one source owns the transmitter
  localparam state_t ST_SEP    = 2'd2;  // emitting the inter-message space

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_NUL   = 8'h00;  // also means "no write" on tx_ascii

endpackage
`default_nettype wire

// File: rtl/morse_tx_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : morse_tx_arbiter_if                                           |
// | Description : Byte-stream request bundle from N ASCII sources into the     |
// |               morse_tx arbiter.                                            |
// | Ports       : req_valid[N]  source i presents a byte                       |
// |               req_data[8N]  byte of source i on req_data[8i+:8]            |
// |               req_last[N]   byte closes the message                        |
// |               req_ready[N]  byte taken this cycle (valid && ready)         |
// |               master = sources side, slave = arbiter side                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface morse_tx_arbiter_if #(
  parameter int N = 4
);

  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    output req_ready
  );

endinterface
`default_nettype wire

// File: rtl/morse_tx_arbiter_rr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_arbiter                                                    |
// | Description : Combinational rotate-priority pick. Searches i_req starting  |
// |               at i_ptr+1 (mod N) and returns the first set index.          |
// | Ports       : i_req[N]   request vector                                    |
// |               i_ptr      index of the previous winner                      |
// |               o_found    at least one request is set                       |
// |               o_idx      winning index (0 when none found)                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N = 4
) (
  input  wire [N-1:0]         i_req,
  input  wire [$clog2(N)-1:0] i_ptr,
  output logic                o_found,
  output logic [$clog2(N)-1:0] o_idx
);

  localparam int W = $clog2(N);

  int           w_sum;
  logic [W-1:0] w_cand;

  // Walk the offsets from farthest to nearest so the nearest hit is the
  // last assignment and therefore wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_sum   = 0;
    w_cand  = '0;
    for (int k = N; k >= 1; k--) begin
      w_sum = int'(i_ptr) + k;
      if (w_sum >= N) begin
        w_sum = w_sum - N;
      end
      w_cand = w_sum[W-1:0];
      if (i_req[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/morse_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : morse_tx_arbiter                                              |
// | Description : Shares one morse_tx between N ASCII sources. A source owns   |
// |               the transmitter for a whole message (round-robin choice),    |
// |               bytes are paced against the tx FIFO full flag, an optional   |
// |               space follows every message, and a stalled message is        |
// |               aborted after TIMEOUT idle cycles.                           |
// | Ports       : clk, rst      clock / synchronous active-high reset          |
// |               req_if        slave side of the source request bundle        |
// |               o_tx_ascii    to morse_tx.ascii_in, 0x00 = no write          |
// |               i_tx_full     morse_tx.full                                  |
// |               o_grant_valid a source currently owns the transmitter        |
// |               o_grant_id    owning source index                            |
// |               o_abort       one-cycle pulse, message dropped by timeout    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module morse_tx_arbiter
  import morse_tx_arbiter_pkg::*;
#(
  parameter int N          = 4,
  parameter int TIMEOUT    = 1024,
  parameter int INSERT_SEP = 1
) (
  input  wire                  clk,
  input  wire                  rst,
  morse_tx_arbiter_if.slave    req_if,
  output logic [7:0]           o_tx_ascii,
  input  wire                  i_tx_full,
  output logic                 o_grant_valid,
  output logic [$clog2(N)-1:0] o_grant_id,
  output logic                 o_abort
);

  localparam int W  = $clog2(N);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [W-1:0]  c_PTR_RESET     = W'(N - 1);
  // Timer value from which one more idle cycle reaches TIMEOUT-1.
  localparam logic [TW-1:0] c_TIMER_PRE_END = TW'(TIMEOUT - 2);
  localparam state_t        c_AFTER_MSG     = (INSERT_SEP != 0) ? ST_SEP : ST_IDLE;

  state_t        r_state;
  state_t        w_next_state;
  logic [W-1:0]  r_ptr;
  logic [W-1:0]  r_grant_id;
  logic [7:0]    r_tx_ascii;
  logic [TW-1:0] r_timer;
  logic          r_abort;

  logic          w_found;
  logic [W-1:0]  w_pick;
  logic          w_gnt_valid;
  logic          w_gnt_last;
  logic [7:0]    w_gnt_data;
  logic          w_can_write;
  logic          w_accept;
  logic          w_idle_tick;
  logic          w_timeout;
  logic          w_msg_end;
  logic          w_sep_write;

  rr_arbiter #(
    .N (N)
  ) u_rr (
    .i_req   (req_if.req_valid),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  assign w_gnt_valid = req_if.req_valid[r_grant_id];
  assign w_gnt_last  = req_if.req_last[r_grant_id];
  assign w_gnt_data  = req_if.req_data[{r_grant_id, 3'b000} +: 8];

  // A write may only go out when the previous registered write has cleared;
  // this both forces a gap cycle and lets the full flag catch up.
  assign w_can_write = !i_tx_full && (r_tx_ascii == ASCII_NUL);
  assign w_accept    = (r_state == ST_STREAM) && w_can_write && w_gnt_valid;
  // Idle means the owner has nothing to offer; back-pressure does not count.
  assign w_idle_tick = (r_state == ST_STREAM) && !w_gnt_valid;
  assign w_timeout   = w_idle_tick && (r_timer == c_TIMER_PRE_END);
  assign w_msg_end   = (w_accept && w_gnt_last) || w_timeout;
  assign w_sep_write = (r_state == ST_SEP) && w_can_write;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_next_state = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (w_msg_end) begin
          w_next_state = c_AFTER_MSG;
        end
      end
      ST_SEP: begin
        if (w_sep_write) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    req_if.req_ready = '0;
    o_grant_valid    = 1'b0;
    if (r_state == ST_STREAM) begin
      req_if.req_ready[r_grant_id] = w_can_write;
      o_grant_valid                = 1'b1;
    end
  end

  // Grant, pointer, timer and write register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= c_PTR_RESET;
      r_grant_id <= '0;
      r_tx_ascii <= ASCII_NUL;
      r_timer    <= '0;
      r_abort    <= 1'b0;
    end else begin
      r_tx_ascii <= ASCII_NUL;
      r_abort    <= 1'b0;

      if ((r_state == ST_IDLE) && w_found) begin
        r_grant_id <= w_pick;
        r_ptr      <= w_pick;
        r_timer    <= '0;
      end

      // A NUL byte is consumed like any other but leaves tx_ascii at 0.
      if (w_accept) begin
        r_tx_ascii <= w_gnt_data;
        r_timer    <= '0;
      end else if (w_idle_tick) begin
        r_timer <= r_timer + 1'b1;
      end

      if (w_timeout) begin
        r_abort <= 1'b1;
      end

      if (w_sep_write) begin
        r_tx_ascii <= ASCII_SPACE;
      end
    end
  end

  assign o_tx_ascii = r_tx_ascii;
  assign o_grant_id = r_grant_id;
  assign o_abort    = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_morse_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_morse_tx_arbiter                                           |
// | Description : Bench for morse_tx_arbiter. Two instances (N=4, TIMEOUT=8),  |
// |               one with the space separator and one without, each fed by   |
// |               queue-based sources and checked every cycle against a       |
// |               message-level model, plus literal expectations per scenario.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_morse_tx_arbiter;

  localparam int N       = 4;
  localparam int TIMEOUT = 8;
  localparam int ND      = 2;   // dut 0: INSERT_SEP=1, dut 1: INSERT_SEP=0
  localparam int QD      = 32;
  localparam int LD      = 64;

  logic clk;
  logic rst;

  logic [N-1:0]   s_valid [ND];
  logic [8*N-1:0] s_data  [ND];
  logic [N-1:0]   s_last  [ND];
  logic [ND-1:0]  tx_full;

  wire [7:0]   d_tx    [ND];
  wire [N-1:0] d_ready [ND];
  wire         d_gv    [ND];
  wire [1:0]   d_gid   [ND];
  wire         d_abort [ND];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar d = 0; d < ND; d++) begin : g_dut
    morse_tx_arbiter_if #(.N(N)) u_if ();

    assign u_if.req_valid = s_valid[d];
    assign u_if.req_data  = s_data[d];
    assign u_if.req_last  = s_last[d];
    assign d_ready[d]     = u_if.req_ready;

    morse_tx_arbiter #(
      .N          (N),
      .TIMEOUT    (TIMEOUT),
      .INSERT_SEP ((d == 0) ? 1 : 0)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .req_if        (u_if),
      .o_tx_ascii    (d_tx[d]),
      .i_tx_full     (tx_full[d]),
      .o_grant_valid (d_gv[d]),
      .o_grant_id    (d_gid[d]),
      .o_abort       (d_abort[d])
    );
  end

  // Source queues: {last, byte}
  logic [8:0] q_mem [ND][N][QD];
  int         q_wr  [ND][N];
  int         q_rd  [ND][N];

  // Observation logs
  logic [7:0] wl_val [ND][LD];
  int         wl_cyc [ND][LD];
  int         wl_n   [ND];
  int         al_src [ND][LD];
  logic [7:0] al_byte[ND][LD];
  int         al_n   [ND];
  int         ab_n   [ND];
  int         ab_cyc [ND];
  int         ab_gv  [ND];

  // Model: owner (-1 = nobody), pending separator, write of the current cycle,
  // idle cycles since the last byte, abort of the current cycle, last winner.
  int         m_owner[ND];
  bit         m_sep  [ND];
  logic [7:0] m_tx   [ND];
  int         m_idle [ND];
  bit         m_abort[ND];
  int         m_ptr  [ND];
  int         m_gid  [ND];

  int checks;
  int errors;
  int cyc;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int d, input int s, input logic [7:0] b, input bit last);
    q_mem[d][s][q_wr[d][s] % QD] = {last, b};
    q_wr[d][s]++;
  endtask

  task automatic drive_srcs();
    for (int d = 0; d < ND; d++) begin
      for (int s = 0; s < N; s++) begin
        logic [8:0] e;
        e = q_mem[d][s][q_rd[d][s] % QD];
        s_valid[d][s]       = (q_rd[d][s] < q_wr[d][s]);
        s_data[d][8*s +: 8] = e[7:0];
        s_last[d][s]        = e[8];
      end
    end
  endtask

  function automatic bit sep_en(input int d);
    return (d == 0);
  endfunction

  task automatic model_reset(input int d);
    m_owner[d] = -1;
    m_sep[d]   = 1'b0;
    m_tx[d]    = 8'h00;
    m_idle[d]  = 0;
    m_abort[d] = 1'b0;
    m_ptr[d]   = N - 1;
    m_gid[d]   = 0;
  endtask

  // Advance the model by one clock edge using the inputs present now.
  task automatic model_step(input int d, input bit r);
    logic [7:0] nt;
    bit         na;
    int         o;
    if (r) begin
      model_reset(d);
      return;
    end
    nt = 8'h00;
    na = 1'b0;
    if (m_owner[d] >= 0) begin
      o = m_owner[d];
      if (s_valid[d][o]) begin
        if (!tx_full[d] && m_tx[d] == 8'h00) begin
          nt        = s_data[d][8*o +: 8];
          m_idle[d] = 0;
          if (s_last[d][o]) begin
            m_owner[d] = -1;
            m_sep[d]   = sep_en(d);
          end
        end
      end else begin
        m_idle[d]++;
        if (m_idle[d] == TIMEOUT - 1) begin
          na         = 1'b1;
          m_owner[d] = -1;
          m_sep[d]   = sep_en(d);
        end
      end
    end else if (m_sep[d]) begin
      if (!tx_full[d] && m_tx[d] == 8'h00) begin
        nt       = 8'h20;
        m_sep[d] = 1'b0;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr[d] + k) % N;
        if (m_owner[d] < 0 && s_valid[d][c]) begin
          m_owner[d] = c;
          m_gid[d]   = c;
          m_ptr[d]   = c;
          m_idle[d]  = 0;
        end
      end
    end
    m_tx[d]    = nt;
    m_abort[d] = na;
  endtask

  // One clock cycle: drive sources, compare at the falling edge, log, step
  // the model, then retire accepted bytes after the rising edge.
  task automatic tick();
    logic [N-1:0] fire [ND];
    logic [N-1:0] er;
    bit           rs;
    drive_srcs();
    @(negedge clk);
    rs = rst;
    for (int d = 0; d < ND; d++) begin
      er = '0;
      if (m_owner[d] >= 0 && !tx_full[d] && m_tx[d] == 8'h00) er[m_owner[d]] = 1'b1;
      chk($sformatf("dut%0d tx_ascii", d), int'(d_tx[d]), int'(m_tx[d]));
      chk($sformatf("dut%0d req_ready", d), int'(d_ready[d]), int'(er));
      chk($sformatf("dut%0d grant_valid", d), int'(d_gv[d]), int'(m_owner[d] >= 0));
      chk($sformatf("dut%0d grant_id", d), int'(d_gid[d]), m_gid[d]);
      chk($sformatf("dut%0d abort", d), int'(d_abort[d]), int'(m_abort[d]));

      if (d_tx[d] != 8'h00 && wl_n[d] < LD) begin
        wl_val[d][wl_n[d]] = d_tx[d];
        wl_cyc[d][wl_n[d]] = cyc;
        wl_n[d]++;
      end
      if (d_abort[d] === 1'b1) begin
        ab_n[d]++;
        ab_cyc[d] = cyc;
        ab_gv[d]  = int'(d_gv[d]);
      end
      fire[d] = rs ? '0 : (s_valid[d] & d_ready[d]);
      for (int s = 0; s < N; s++) begin
        if (fire[d][s] && al_n[d] < LD) begin
          al_src[d][al_n[d]]  = s;
          al_byte[d][al_n[d]] = s_data[d][8*s +: 8];
          al_n[d]++;
        end
      end
      model_step(d, rs);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < ND; d++) begin
      for (int s = 0; s < N; s++) begin
        if (rs) q_rd[d][s] = q_wr[d][s];
        else if (fire[d][s]) q_rd[d][s]++;
      end
    end
  endtask

  function automatic bit drained(input int d);
    for (int s = 0; s < N; s++) begin
      if (q_rd[d][s] != q_wr[d][s]) return 1'b0;
    end
    return (m_owner[d] < 0) && !m_sep[d] && (m_tx[d] == 8'h00);
  endfunction

  task automatic run_drain(input int d, input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!drained(d) && n < budget);
    chk($sformatf("dut%0d drain within %0d cycles", d, budget), int'(drained(d)), 1);
  endtask

  task automatic check_idle_outputs(input int d);
    chk($sformatf("dut%0d reset tx_ascii", d), int'(d_tx[d]), 0);
    chk($sformatf("dut%0d reset req_ready", d), int'(d_ready[d]), 0);
    chk($sformatf("dut%0d reset grant_valid", d), int'(d_gv[d]), 0);
    chk($sformatf("dut%0d reset grant_id", d), int'(d_gid[d]), 0);
    chk($sformatf("dut%0d reset abort", d), int'(d_abort[d]), 0);
  endtask

  initial begin
    int wb, ab, an, wn, rc, n;

    checks  = 0;
    errors  = 0;
    cyc     = 0;
    rst     = 1'b1;
    tx_full = '0;
    for (int d = 0; d < ND; d++) begin
      s_valid[d] = '0;
      s_data[d]  = '0;
      s_last[d]  = '0;
      wl_n[d] = 0; al_n[d] = 0; ab_n[d] = 0; ab_cyc[d] = -1; ab_gv[d] = -1;
      for (int s = 0; s < N; s++) begin
        q_wr[d][s] = 0;
        q_rd[d][s] = 0;
        for (int k = 0; k < QD; k++) q_mem[d][s][k] = '0;
      end
      for (int k = 0; k < LD; k++) begin
        wl_val[d][k] = 8'h00; wl_cyc[d][k] = -1;
        al_src[d][k] = -1;    al_byte[d][k] = 8'hFF;
      end
      model_reset(d);
    end

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int d = 0; d < ND; d++) check_idle_outputs(d);

    // 1: "SOS" from source 0 -> 53,0,4F,0,53,0,20 with grant_id 0
    wb = wl_n[0]; ab = al_n[0];
    push(0, 0, 8'h53, 1'b0);
    push(0, 0, 8'h4F, 1'b0);
    push(0, 0, 8'h53, 1'b1);
    run_drain(0, 100);
    chk("sos write count", wl_n[0] - wb, 4);
    chk("sos byte0", int'(wl_val[0][wb]),   'h53);
    chk("sos byte1", int'(wl_val[0][wb+1]), 'h4F);
    chk("sos byte2", int'(wl_val[0][wb+2]), 'h53);
    chk("sos separator", int'(wl_val[0][wb+3]), 'h20);
    chk("sos spacing 0-1", wl_cyc[0][wb+1] - wl_cyc[0][wb], 2);
    chk("sos spacing 1-2", wl_cyc[0][wb+2] - wl_cyc[0][wb+1], 2);
    chk("sos spacing 2-sep", wl_cyc[0][wb+3] - wl_cyc[0][wb+2], 2);
    chk("sos owner", al_src[0][ab+2], 0);

    // 2: sources 1 and 3 together -> 1 completes first; then all four -> 0,1,2,3
    ab = al_n[0];
    push(0, 1, 8'h41, 1'b0); push(0, 1, 8'h42, 1'b1);
    push(0, 3, 8'h43, 1'b0); push(0, 3, 8'h44, 1'b1);
    run_drain(0, 100);
    chk("rr pair src0", al_src[0][ab],   1);
    chk("rr pair src1", al_src[0][ab+1], 1);
    chk("rr pair src2", al_src[0][ab+2], 3);
    chk("rr pair src3", al_src[0][ab+3], 3);
    ab = al_n[0];
    for (int s = 0; s < N; s++) push(0, s, 8'(8'h45 + s), 1'b1);
    run_drain(0, 100);
    for (int k = 0; k < N; k++) chk($sformatf("rr all order %0d", k), al_src[0][ab+k], k);

    // 3: tx_full held 50 cycles after the first byte of "XYZ"
    ab = al_n[0];
    push(0, 0, 8'h58, 1'b0); push(0, 0, 8'h59, 1'b0); push(0, 0, 8'h5A, 1'b1);
    n = 0;
    while (al_n[0] == ab && n < 20) begin tick(); n++; end
    chk("full first accept", al_n[0] - ab, 1);
    tx_full[0] = 1'b1;
    wn = wl_n[0]; an = ab_n[0];
    repeat (50) tick();
    chk("full writes in window", wl_n[0] - wn, 1);
    chk("full pending write is X", int'(wl_val[0][wn]), 'h58);
    chk("full accepts in window", al_n[0] - ab, 1);
    chk("full no abort", ab_n[0] - an, 0);
    tx_full[0] = 1'b0;
    rc = cyc;
    n = 0;
    while (wl_n[0] == wn + 1 && n < 10) begin tick(); n++; end
    chk("release next byte", int'(wl_val[0][wn+1]), 'h59);
    chk("release latency within 2", int'((wl_cyc[0][wn+1] - rc) >= 1 && (wl_cyc[0][wn+1] - rc) <= 2), 1);
    run_drain(0, 100);

    // 4: source 2 sends 'A' without last and goes quiet; abort 7 cycles after
    //    'A' appears on tx_ascii, then the separator
    wb = wl_n[0]; an = ab_n[0];
    push(0, 2, 8'h41, 1'b0);
    run_drain(0, 100);
    chk("timeout A written", int'(wl_val[0][wb]), 'h41);
    chk("timeout abort count", ab_n[0] - an, 1);
    chk("timeout abort delay", ab_cyc[0] - wl_cyc[0][wb], 7);
    chk("timeout grant_valid at abort", ab_gv[0], 0);
    chk("timeout separator", int'(wl_val[0][wb+1]), 'h20);
    chk("timeout separator cycle", wl_cyc[0][wb+1] - ab_cyc[0], 1);

    // 5: NUL mid-message, no separator instance
    wb = wl_n[1]; ab = al_n[1];
    push(1, 0, 8'h48, 1'b0); push(1, 0, 8'h00, 1'b0); push(1, 0, 8'h49, 1'b1);
    run_drain(1, 100);
    repeat (5) tick();
    chk("nul accepts", al_n[1] - ab, 3);
    chk("nul accepted byte", int'(al_byte[1][ab+1]), 0);
    chk("nul write count", wl_n[1] - wb, 2);
    chk("nul write H", int'(wl_val[1][wb]), 'h48);
    chk("nul write I", int'(wl_val[1][wb+1]), 'h49);

    // 6: reset mid-message, then arbitration starts again from source 0
    ab = al_n[0];
    push(0, 1, 8'h4C, 1'b0); push(0, 1, 8'h4D, 1'b0); push(0, 1, 8'h4E, 1'b0);
    push(0, 1, 8'h4F, 1'b0); push(0, 1, 8'h50, 1'b1);
    n = 0;
    while (al_n[0] < ab + 2 && n < 30) begin tick(); n++; end
    chk("pre-reset accepts", al_n[0] - ab, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int d = 0; d < ND; d++) check_idle_outputs(d);
    ab = al_n[0];
    push(0, 0, 8'h51, 1'b1);
    push(0, 2, 8'h52, 1'b1);
    run_drain(0, 100);
    chk("post-reset first owner", al_src[0][ab], 0);
    chk("post-reset second owner", al_src[0][ab+1], 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
